mem_responder: RTL and testbench

- Memory-side responder for the CPU's fetch/load/store requests.
- The control unit's fetch and memory states drive req_* into this block.
- Serves each request from an internal byte-wide RAM after a programmable number of wait states, then returns read data or a write acknowledgement on a valid/ready response channel.
- Single outstanding request. Sits between the control unit/datapath and program/data storage.

---
 rtl/mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
//============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for CPU fetch/load/store requests. Each
//            request is served from an internal byte-wide RAM after
//            WAIT_STATES extra cycles. Read data or a write acknowledgement
//            is then returned on a valid/ready response channel. Only one
//            request is in flight at a time.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   DEPTH        number of 8-bit words implemented (2..256). Legal addresses
//                are 0..DEPTH-1.
//   WAIT_STATES  extra cycles between request accept and response (0..15).
//                The wait counter is 4 bits wide.
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low (0 = in reset)
//   req_valid    request present
//   req_ready    responder can accept a request (IDLE only)
//   req_write    1 = store, 0 = load/fetch
//   req_addr     word address
//   req_wdata    store data
//   rsp_valid    response present (RESPOND state)
//   rsp_ready    requester accepts the response
//   rsp_rdata    load data (0 for writes and for errors)
//   rsp_err      address was >= DEPTH
//   busy         FSM is not in IDLE
// Optional feature (macro MEMRSP_LOAD_PORT_EN)
//   ld_en        program preload enable. Acts in IDLE only and blocks requests.
//   ld_addr      preload address. Ignored when >= DEPTH.
//   ld_data      preload data
//============================================================================
module mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy
`ifdef MEMRSP_LOAD_PORT_EN
   ,
   input  logic       ld_en,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_data
`endif
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic       accept;
   logic       do_access;
   logic       ld_active;

   // Request captured at the accept edge. It is used by the deferred access.
   logic       lat_write;
   logic [7:0] lat_addr;
   logic [7:0] lat_wdata;

   logic [7:0] rdata_q;
   logic       err_q;

   logic [7:0] mem [0:DEPTH-1];

   // Access operands. With zero wait states the access happens at the accept
   // edge, so the live request inputs are used. Otherwise the latched copy is
   // used, which keeps later changes on req_* from reaching the access.
   logic       acc_write;
   logic [7:0] acc_addr;
   logic [7:0] acc_wdata;
   logic       acc_in_range;
   logic [7:0] acc_rdata;

`ifdef MEMRSP_LOAD_PORT_EN
   logic       ld_in_range;
   // Gating with reset stops a preload while reset is asserted.
   assign ld_active   = ld_en & reset & (state == IDLE);
   assign ld_in_range = ({1'b0, ld_addr} < 9'(DEPTH));
`else
   assign ld_active   = 1'b0;
`endif

   assign acc_write    = (state == IDLE) ? req_write : lat_write;
   assign acc_addr     = (state == IDLE) ? req_addr  : lat_addr;
   assign acc_wdata    = (state == IDLE) ? req_wdata : lat_wdata;
   // Use a 9-bit compare so that DEPTH = 256 is representable.
   assign acc_in_range = ({1'b0, acc_addr} < 9'(DEPTH));
   assign acc_rdata    = (acc_in_range && !acc_write) ? mem[acc_addr[AW-1:0]] : 8'h00;

   //-------------------------------------------------------------------------
   // FSM: state register
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //-------------------------------------------------------------------------
   // FSM: next state and handshake strobes
   //-------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      accept    = 1'b0;
      do_access = 1'b0;
      case (state)
         IDLE: begin
            // req_ready is held low during reset so that nothing can be
            // accepted until reset is released.
            req_ready = reset & ~ld_active;
            accept    = req_valid & req_ready;
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  state_nxt = RESPOND;
               end else begin
                  state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               do_access = 1'b1;
               state_nxt = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   //-------------------------------------------------------------------------
   // Request latch, wait counter and response registers
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= 8'h00;
         lat_wdata <= 8'h00;
         rdata_q   <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
         end else if ((state == ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (do_access) begin
            rdata_q <= acc_rdata;
            err_q   <= ~acc_in_range;
         end else if ((state == RESPOND) && rsp_ready) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
         end
      end
   end

   //-------------------------------------------------------------------------
   // RAM write port. Reset does not clear the RAM. A write that is still
   // waiting in ACCESS is dropped if reset arrives first, because reset
   // returns the FSM to IDLE before the access edge.
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (do_access && acc_write && acc_in_range) begin
         mem[acc_addr[AW-1:0]] <= acc_wdata;
      end
`ifdef MEMRSP_LOAD_PORT_EN
      else if (ld_active && ld_in_range) begin
         mem[ld_addr[AW-1:0]] <= ld_data;
      end
`endif
   end

   assign rsp_valid = (state == RESPOND);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. It runs three instances:
//              0: DEPTH=256, WAIT_STATES=1
//              1: DEPTH=256, WAIT_STATES=0
//              2: DEPTH=16,  WAIT_STATES=2
//            Table-driven requests are checked through a response
//            scoreboard. Hand-written sequences cover the stall, reset and
//            preload cases.
// Revision : 1.0 - initial release
//============================================================================
module tb_mem_responder;

   localparam int NI = 3;

   function automatic int ws_of(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   function automatic int depth_of(input int k);
      return (k == 2) ? 16 : 256;
   endfunction

   logic          clk = 1'b0;
   logic          reset;
   logic [NI-1:0] req_valid, req_write, rsp_ready;
   logic [NI-1:0] req_ready, rsp_valid, rsp_err, busy;
   logic [7:0]    req_addr  [NI];
   logic [7:0]    req_wdata [NI];
   logic [7:0]    rsp_rdata [NI];
`ifdef MEMRSP_LOAD_PORT_EN
   logic [NI-1:0] ld_en;
   logic [7:0]    ld_addr [NI];
   logic [7:0]    ld_data [NI];
`endif

   always #5 clk = ~clk;

   for (genvar i = 0; i < NI; i++) begin : g_dut
      mem_responder #(
         .DEPTH       (depth_of(i)),
         .WAIT_STATES (ws_of(i))
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[i]),
         .req_ready (req_ready[i]),
         .req_write (req_write[i]),
         .req_addr  (req_addr[i]),
         .req_wdata (req_wdata[i]),
         .rsp_valid (rsp_valid[i]),
         .rsp_ready (rsp_ready[i]),
         .rsp_rdata (rsp_rdata[i]),
         .rsp_err   (rsp_err[i]),
         .busy      (busy[i])
`ifdef MEMRSP_LOAD_PORT_EN
         ,
         .ld_en     (ld_en[i]),
         .ld_addr   (ld_addr[i]),
         .ld_data   (ld_data[i])
`endif
      );
   end

   //-------------------------------------------------------------------------
   // Comparison bookkeeping
   //-------------------------------------------------------------------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   //-------------------------------------------------------------------------
   // Scoreboard: expected responses are pushed at the accept edge and popped
   // on the response handshake.
   //-------------------------------------------------------------------------
   typedef struct {
      int         inst;
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   exp_t sbq[$];

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (reset && rsp_valid[k] && rsp_ready[k]) begin
            if (sbq.size() == 0) begin
               chk("response without request", sbq.size(), 1);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("rsp instance", k, e.inst);
               chk("rsp_rdata", rsp_rdata[k], e.rdata);
               chk("rsp_err", rsp_err[k], e.err);
            end
         end
      end
   end

   //-------------------------------------------------------------------------
   // One request. The task is called at posedge+1 with the instance in IDLE.
   // It returns at posedge+1 after the handshake if rsp_ready is high.
   // Otherwise it returns at the negedge where rsp_valid is first seen.
   //-------------------------------------------------------------------------
   task automatic do_req(input int k, input bit wr, input bit [7:0] a, input bit [7:0] d,
                         input bit [7:0] er, input bit ee, output time t_valid);
      int n;
      req_write[k] = wr;
      req_addr[k]  = a;
      req_wdata[k] = d;
      req_valid[k] = 1'b1;
      @(negedge clk);
      chk("req_ready in IDLE", req_ready[k], 1'b1);
      @(posedge clk);
      sbq.push_back('{k, er, ee});
      #1;
      // Scramble the request inputs. The in-flight access must not use them.
      req_valid[k] = 1'b0;
      req_write[k] = ~wr;
      req_addr[k]  = 8'($urandom);
      req_wdata[k] = 8'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!rsp_valid[k]) begin
            chk("req_ready while busy", req_ready[k], 1'b0);
            chk("busy while waiting", busy[k], 1'b1);
         end
      end while (!rsp_valid[k] && n < 40);
      chk("rsp latency", n, ws_of(k) + 1);
      chk("req_ready in RESPOND", req_ready[k], 1'b0);
      t_valid = $time;
      if (rsp_ready[k]) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      int      inst;
      bit      wr;
      bit [7:0] addr;
      bit [7:0] wdata;
      bit [7:0] exp_rdata;
      bit      exp_err;
   } vec_t;

   function automatic vec_t mk(input int inst, input bit wr, input bit [7:0] a,
                               input bit [7:0] d, input bit [7:0] er, input bit ee);
      vec_t v;
      v.inst = inst; v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [21];
      time  t;
      time  t_prev;

      vecs[0]  = mk(0, 1, 8'h10, 8'hA5, 8'h00, 0);
      vecs[1]  = mk(0, 0, 8'h10, 8'h00, 8'hA5, 0);
      vecs[2]  = mk(0, 1, 8'hFF, 8'h3C, 8'h00, 0);
      vecs[3]  = mk(0, 0, 8'hFF, 8'h00, 8'h3C, 0);
      vecs[4]  = mk(0, 1, 8'h10, 8'h01, 8'h00, 0);
      vecs[5]  = mk(0, 0, 8'h10, 8'h00, 8'h01, 0);
      vecs[6]  = mk(1, 1, 8'h00, 8'h11, 8'h00, 0);
      vecs[7]  = mk(1, 1, 8'h01, 8'h22, 8'h00, 0);
      vecs[8]  = mk(1, 1, 8'h02, 8'h33, 8'h00, 0);
      vecs[9]  = mk(1, 1, 8'h03, 8'h44, 8'h00, 0);
      vecs[10] = mk(1, 0, 8'h00, 8'h00, 8'h11, 0);
      vecs[11] = mk(1, 0, 8'h01, 8'h00, 8'h22, 0);
      vecs[12] = mk(1, 0, 8'h02, 8'h00, 8'h33, 0);
      vecs[13] = mk(1, 0, 8'h03, 8'h00, 8'h44, 0);
      vecs[14] = mk(2, 1, 8'h00, 8'h6B, 8'h00, 0);
      vecs[15] = mk(2, 1, 8'h20, 8'hFF, 8'h00, 1);
      vecs[16] = mk(2, 0, 8'h20, 8'h00, 8'h00, 1);
      vecs[17] = mk(2, 0, 8'h00, 8'h00, 8'h6B, 0);
      vecs[18] = mk(2, 1, 8'h0F, 8'h9C, 8'h00, 0);
      vecs[19] = mk(2, 0, 8'h0F, 8'h00, 8'h9C, 0);
      vecs[20] = mk(2, 0, 8'h10, 8'h00, 8'h00, 1);

      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      rsp_ready = '1;
      for (int k = 0; k < NI; k++) begin
         req_addr[k]  = 8'h00;
         req_wdata[k] = 8'h00;
      end
`ifdef MEMRSP_LOAD_PORT_EN
      ld_en = '0;
      for (int k = 0; k < NI; k++) begin
         ld_addr[k] = 8'h00;
         ld_data[k] = 8'h00;
      end
`endif
      t      = 0;
      t_prev = 0;

      // Reset state
      #1 reset = 1'b0;
      #11;
      for (int k = 0; k < NI; k++) begin
         chk("reset rsp_valid", rsp_valid[k], 1'b0);
         chk("reset rsp_rdata", rsp_rdata[k], 8'h00);
         chk("reset rsp_err", rsp_err[k], 1'b0);
         chk("reset busy", busy[k], 1'b0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk("req_ready after reset", req_ready[k], 1'b1);
      @(posedge clk);
      #1;

      // Table-driven requests. Consecutive requests to the same instance
      // must complete once every WAIT_STATES+2 cycles.
      for (int i = 0; i < 21; i++) begin
         do_req(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, t);
         if (i > 0 && vecs[i-1].inst == vecs[i].inst)
            chk("throughput", 32'(t - t_prev), 32'((ws_of(vecs[i].inst) + 2) * 10));
         t_prev = t;
      end

      // Response stall: rsp_ready is held low for 5 cycles.
      do_req(0, 1, 8'h30, 8'h5A, 8'h00, 0, t);
      rsp_ready[0] = 1'b0;
      do_req(0, 0, 8'h30, 8'h00, 8'h5A, 0, t);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         chk("stall rsp_valid", rsp_valid[0], 1'b1);
         chk("stall rsp_rdata", rsp_rdata[0], 8'h5A);
         chk("stall busy", busy[0], 1'b1);
         chk("stall req_ready", req_ready[0], 1'b0);
      end
      @(posedge clk);
      #1 rsp_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post-stall rsp_valid", rsp_valid[0], 1'b0);
      chk("post-stall rsp_rdata", rsp_rdata[0], 8'h00);
      chk("post-stall busy", busy[0], 1'b0);
      chk("post-stall req_ready", req_ready[0], 1'b1);
      @(posedge clk);
      #1;

      // Reset during ACCESS of a write. The write must not reach the RAM.
      do_req(0, 1, 8'h05, 8'h00, 8'h00, 0, t);
      req_write[0] = 1'b1;
      req_addr[0]  = 8'h05;
      req_wdata[0] = 8'h77;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      chk("busy in ACCESS", busy[0], 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("async reset busy", busy[0], 1'b0);
      chk("async reset rsp_valid", rsp_valid[0], 1'b0);
      chk("async reset rsp_rdata", rsp_rdata[0], 8'h00);
      chk("async reset rsp_err", rsp_err[0], 1'b0);
      chk("req_ready in reset", req_ready[0], 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("req_ready after mid reset", req_ready[0], 1'b1);
      @(posedge clk);
      #1;
      do_req(0, 0, 8'h05, 8'h00, 8'h00, 0, t);
      // The RAM keeps its contents across reset.
      do_req(0, 0, 8'h10, 8'h00, 8'h01, 0, t);

`ifdef MEMRSP_LOAD_PORT_EN
      // Preload has priority over a pending request.
      req_write[1] = 1'b0;
      req_addr[1]  = 8'h01;
      req_valid[1] = 1'b1;
      ld_en[1]     = 1'b1;
      ld_addr[1]   = 8'h00;
      ld_data[1]   = 8'h3C;
      @(negedge clk);
      chk("req_ready during load", req_ready[1], 1'b0);
      chk("busy during load", busy[1], 1'b0);
      @(posedge clk);
      #1;
      ld_addr[1] = 8'h01;
      ld_data[1] = 8'hC3;
      @(negedge clk);
      chk("req_ready during load", req_ready[1], 1'b0);
      @(posedge clk);
      #1;
      ld_en[1]     = 1'b0;
      req_valid[1] = 1'b0;
      do_req(1, 0, 8'h01, 8'h00, 8'hC3, 0, t);
      do_req(1, 0, 8'h00, 8'h00, 8'h3C, 0, t);
`endif

      repeat (3) @(posedge clk);
      chk("scoreboard drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
